// File: rtl/sst_pkg.sv
// Shared types for the save-state sequencer: FSM states, error codes and the default index address.
// No logic of its own.
package sst_pkg;

  typedef enum logic [3:0] {
    IDLE,
    IDX_RD,
    IDX_MEM,
    SAVE_RD,
    SAVE_MEM,
    LOAD_MEM,
    LOAD_ARM,
    LOAD_STB,
    VFY,
    FIN
  } sst_state_t;

  localparam logic [1:0] SST_ERR_NONE = 2'd0;
  localparam logic [1:0] SST_ERR_IDX  = 2'd1;
  localparam logic [1:0] SST_ERR_TMO  = 2'd2;
  localparam logic [1:0] SST_ERR_VFY  = 2'd3;

  localparam int SST_IDX_ADDR = 127;

endpackage

// File: rtl/m2_edge_sync.sv
// M2 falling-edge detector: 2-flop synchronizer plus edge register; m2_fall is seen 3 clocks after the pin falls.
// No backpressure; m2_fall is a one-clock pulse.
module m2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic m2,
  output logic m2_fall
);

  // sh[1:0] synchronize the pin, sh[2] holds the previous synchronized level
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (rst) sh <= 3'b000;
    else     sh <= {sh[1:0], m2};
  end

  assign m2_fall = sh[2] & ~sh[1];

endmodule

// File: rtl/sst_seq.sv
// Save/load sequencer between the mapper sst bus and an external state buffer; one register per (3 + mem latency) clocks on save.
// Memory requests hold until mem_ack or ACK_TMO clocks; SST_SEQ_VERIFY_EN adds a post-load readback compare.
module sst_seq
  import sst_pkg::*;
#(
  parameter int REG_CNT  = 6,
  parameter int IDX_ADDR = SST_IDX_ADDR,
  parameter int ACK_TMO  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_save,
  input  logic       start_load,
  output logic       busy,
  output logic       done,
  output logic [1:0] err,
  input  logic       m2,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack
);

  localparam int              TW      = $clog2(ACK_TMO + 1);
  localparam logic [7:0]      LAST    = 8'(REG_CNT - 1);
  localparam logic [7:0]      IDX_A   = 8'(IDX_ADDR);
  localparam logic [TW-1:0]   TMO_LIM = TW'(ACK_TMO);

  sst_state_t    state;
  logic          mode_load;
  logic [7:0]    n;
  logic          settle;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    cur_idx;
  logic          m2_fall;
  logic          acked;
  logic          tmo_hit;
`ifdef SST_SEQ_VERIFY_EN
  logic [7:0]    vfy_dat;
`endif

  m2_edge_sync u_m2 (
    .clk     (clk),
    .rst     (rst),
    .m2      (m2),
    .m2_fall (m2_fall)
  );

  assign acked   = mem_req && mem_ack;
  assign tmo_hit = mem_req && !mem_ack && (tmo_cnt == TMO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_load  <= 1'b0;
      n          <= 8'h00;
      settle     <= 1'b0;
      tmo_cnt    <= '0;
      cur_idx    <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= SST_ERR_NONE;
      sst_act    <= 1'b0;
      sst_addr   <= 8'h00;
      sst_we_reg <= 1'b0;
      sst_dato   <= 8'h00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 8'h00;
      mem_wdata  <= 8'h00;
`ifdef SST_SEQ_VERIFY_EN
      vfy_dat    <= 8'h00;
`endif
    end else begin
      // Shared handshake: drop req after ack, abort on timeout. State arms below override only on ack.
      if (acked) begin
        mem_req <= 1'b0;
        tmo_cnt <= '0;
      end else if (tmo_hit) begin
        mem_req <= 1'b0;
        err     <= SST_ERR_TMO;
        state   <= FIN;
      end else if (mem_req) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_save || start_load) begin
            mode_load <= !start_save;
            busy      <= 1'b1;
            sst_act   <= 1'b1;
            err       <= SST_ERR_NONE;
            sst_addr  <= IDX_A;
            settle    <= 1'b0;
            state     <= IDX_RD;
          end
        end
        IDX_RD: begin
          settle <= 1'b1;
          if (settle) begin
            cur_idx   <= sst_di;
            mem_req   <= 1'b1;
            mem_we    <= !mode_load;
            mem_addr  <= IDX_A;
            mem_wdata <= mode_load ? 8'h00 : sst_di;
            tmo_cnt   <= '0;
            state     <= IDX_MEM;
          end
        end
        IDX_MEM: begin
          if (acked) begin
            n        <= 8'h00;
            settle   <= 1'b0;
            sst_addr <= 8'h00;
            if (mode_load && mem_rdata != cur_idx) begin
              err   <= SST_ERR_IDX;
              state <= FIN;
            end else begin
              state <= mode_load ? LOAD_MEM : SAVE_RD;
            end
          end
        end
        SAVE_RD: begin
          settle <= 1'b1;
          if (settle) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= n;
            mem_wdata <= sst_di;
            tmo_cnt   <= '0;
            state     <= SAVE_MEM;
          end
        end
        SAVE_MEM: begin
          if (acked) begin
            if (n == LAST) begin
              state <= FIN;
            end else begin
              n        <= n + 8'd1;
              sst_addr <= n + 8'd1;
              settle   <= 1'b0;
              state    <= SAVE_RD;
            end
          end
        end
        LOAD_MEM: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= n;
            tmo_cnt  <= '0;
          end else if (acked) begin
            sst_dato <= mem_rdata;
            sst_addr <= n;
            state    <= LOAD_ARM;
          end
        end
        LOAD_ARM: begin
          if (m2_fall) begin
            sst_we_reg <= 1'b1;
            state      <= LOAD_STB;
          end
        end
        // Strobe spans one full M2 period so exactly one CPU negedge samples it.
        LOAD_STB: begin
          if (m2_fall) begin
            sst_we_reg <= 1'b0;
            if (n == LAST) begin
`ifdef SST_SEQ_VERIFY_EN
              n        <= 8'h00;
              sst_addr <= 8'h00;
              settle   <= 1'b0;
              state    <= VFY;
`else
              state    <= FIN;
`endif
            end else begin
              n     <= n + 8'd1;
              state <= LOAD_MEM;
            end
          end
        end
`ifdef SST_SEQ_VERIFY_EN
        VFY: begin
          if (!mem_req) begin
            settle <= 1'b1;
            if (settle) begin
              vfy_dat  <= sst_di;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= n;
              tmo_cnt  <= '0;
            end
          end else if (acked) begin
            if (mem_rdata != vfy_dat) begin
              err   <= SST_ERR_VFY;
              state <= FIN;
            end else if (n == LAST) begin
              state <= FIN;
            end else begin
              n        <= n + 8'd1;
              sst_addr <= n + 8'd1;
              settle   <= 1'b0;
            end
          end
        end
`endif
        FIN: begin
          busy       <= 1'b0;
          sst_act    <= 1'b0;
          done       <= (err == SST_ERR_NONE);
          sst_addr   <= 8'h00;
          sst_dato   <= 8'h00;
          sst_we_reg <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= 8'h00;
          mem_wdata  <= 8'h00;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
